data_delay_prog: RTL and testbench
==================================

Name: data_delay_prog

Overview:
- Runtime-programmable fixed-latency delay line for video-pipeline sideband alignment (syncs, DE, pixel tags).
- Delays each sample by a delay value set at runtime, 1..MAX_DELAY cycles, instead of a compile-time depth.
- Built on a circular buffer with write and read pointers. A FILL/RUN state machine blanks the output valid until the buffer holds a full delay's worth of fresh samples.
- Sits beside the CORDIC pipeline. Software or the control FSM retunes the latency when the pipeline depth mode changes.

Parameters:
- DATA_WIDTH, 8, width of the delayed data word.
- MAX_DELAY, 64, maximum delay in cycles; buffer depth; power of two, minimum 2.
- ADDR_WIDTH, 6, log2(MAX_DELAY); pointer width.
- DEFAULT_DELAY, 5, delay used after reset; must be in 1..MAX_DELAY.

Ports:
- I_video_clk, input, 1, single clock; all logic on its rising edge.
- I_rst_n, input, 1, reset; synchronous, active-low.
- I_delay, input, ADDR_WIDTH+1, requested delay in cycles; sampled only when I_delay_load=1.
- I_delay_load, input, 1, one-cycle strobe that applies I_delay.
- I_data_valid, input, 1, valid flag travelling with I_data.
- I_data, input, DATA_WIDTH, sample to delay.
- O_data, output, DATA_WIDTH, delayed sample.
- O_data_valid, output, 1, delayed valid; qualified by the RUN state.
- O_ready, output, 1, 1 when in RUN (delay settled).
- O_delay, output, ADDR_WIDTH+1, currently active (clamped) delay.
- O_delay_err, output, 1, sticky out-of-range flag for the last load.

Behaviour:
- Reset (I_rst_n=0 at a clock edge):
  - O_data=0, O_data_valid=0, O_ready=0, O_delay_err=0, O_delay=DEFAULT_DELAY.
  - Pointers = 0, fill counter = 0, state = FILL.
  - Buffer RAM is not cleared; FILL masks stale contents.
- Reset mid-operation discards all in-flight samples and behaves exactly as the reset case above.
- Latency: the {I_data, I_data_valid} pair sampled at edge k appears on {O_data, O_data_valid} after edge k+D, where D=O_delay.
  - D=1 must equal a single register stage.
  - Latency is exact for every D in 1..MAX_DELAY.
- Storage: one buffer entry per cycle, regardless of I_data_valid. The valid bit is stored alongside the data. The write pointer wraps modulo MAX_DELAY.
- State FILL:
  - O_ready=0 and O_data_valid=0.
  - The fill counter increments each cycle.
  - When the counter reaches D, the next state is RUN. From that edge, O_data_valid = the stored valid bit of the sample written D cycles earlier.
- State RUN:
  - O_ready=1.
  - O_data_valid = delayed I_data_valid.
  - Stays in RUN until a load or reset.
- Delay load (I_delay_load=1 at edge k):
  - Clamp: I_delay=0 becomes 1; I_delay>MAX_DELAY becomes MAX_DELAY.
  - O_delay_err=1 if a clamp occurred, else 0. It holds until the next load.
  - O_delay updates at edge k.
  - The state goes to FILL with the counter cleared. The read pointer re-derives from the write pointer and the new D.
- Load during FILL restarts FILL with the new D; the counter restarts from 0.
- Load of the same D as the current value still forces a re-FILL, so behaviour is deterministic.
- Load and reset at the same edge: reset wins.
- Wrap-around: a read address of wp-D that crosses below 0 wraps modulo MAX_DELAY. There is no bubble at the wrap.
- D=MAX_DELAY: the write and read entries coincide. Read-before-write semantics are required so the output is the MAX_DELAY-old sample.
- Outside FILL, O_data follows the buffer, the same as in RUN.

Optional Feature:
- Macro: DATA_DELAY_PROG_BLANK_EN.
- Defined: O_data is forced to 0 whenever the state is FILL, so downstream never sees stale RAM data.
- Undefined: O_data outputs raw buffer contents during FILL, which saves a mux. Only O_data_valid and O_ready are blanked.
- RUN behaviour is identical in both builds.

Test Plan:
- Reset, then a ramp I_data=0,1,2,... with I_data_valid=1 -> O_ready rises after 5 cycles; O_data=n exactly 5 cycles after input n; O_delay=5.
- Load I_delay=1 mid-stream -> O_ready=0 for 1 cycle, then O_data equals the input delayed by 1; O_delay_err=0.
- Load I_delay=64, run 200 cycles -> latency exactly 64 across at least 3 pointer wraps; no dropped or repeated samples.
- Load I_delay=0, then load I_delay=100 -> O_delay=1 with O_delay_err=1; then O_delay=64 with O_delay_err=1. A following load of 10 clears O_delay_err.
- Drive an I_data_valid pattern 1,0,1,1,0 with D=3; load D=7 during FILL at count 2 -> FILL restarts, RUN begins 7 cycles after the second load, and the valid pattern reproduces at latency 7.
- Assert I_rst_n=0 for 1 cycle mid-RUN with the blank macro defined -> all outputs 0 the following cycle, O_data=0 throughout the 5-cycle FILL, then normal output.

Source files
------------

// File: rtl/data_delay_prog.sv
// Runtime-programmable delay line (1..MAX_DELAY cycles) on a circular buffer with FILL/RUN valid gating.
// Build option: define DATA_DELAY_PROG_BLANK_EN to force O_data to 0 while filling.
module data_delay_prog #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned MAX_DELAY     = 64,
   parameter int unsigned ADDR_WIDTH    = 6,
   parameter int unsigned DEFAULT_DELAY = 5
) (
   input  logic                  I_video_clk,
   input  logic                  I_rst_n,
   input  logic [ADDR_WIDTH:0]   I_delay,
   input  logic                  I_delay_load,
   input  logic                  I_data_valid,
   input  logic [DATA_WIDTH-1:0] I_data,
   output logic [DATA_WIDTH-1:0] O_data,
   output logic                  O_data_valid,
   output logic                  O_ready,
   output logic [ADDR_WIDTH:0]   O_delay,
   output logic                  O_delay_err
);

   localparam int unsigned DLY_W  = ADDR_WIDTH + 1;
   localparam int unsigned WORD_W = DATA_WIDTH + 1;

`ifdef DATA_DELAY_PROG_BLANK_EN
   localparam bit BLANK_FILL = 1'b1;
`else
   localparam bit BLANK_FILL = 1'b0;
`endif

   typedef enum logic {ST_FILL, ST_RUN} state_t;

   state_t                  state;
   logic [WORD_W-1:0]       mem [MAX_DELAY];
   logic [ADDR_WIDTH-1:0]   wr_ptr;
   logic [ADDR_WIDTH-1:0]   rd_ptr_c;
   logic [DLY_W-1:0]        fill_cnt;
   logic [DLY_W-1:0]        delay_clamp_c;
   logic                    clamp_err_c;
   logic [WORD_W-1:0]       rd_word_c;
   logic [DATA_WIDTH-1:0]   rd_data_c;
   logic [DATA_WIDTH-1:0]   fill_data_c;

   // Requested delay clamped into 1..MAX_DELAY
   always_comb begin
      delay_clamp_c = I_delay;
      clamp_err_c   = 1'b0;
      if (I_delay == '0) begin
         delay_clamp_c = DLY_W'(1);
         clamp_err_c   = 1'b1;
      end else if (I_delay > DLY_W'(MAX_DELAY)) begin
         delay_clamp_c = DLY_W'(MAX_DELAY);
         clamp_err_c   = 1'b1;
      end
   end

   // D = MAX_DELAY truncates to offset 0: read entry coincides with the write entry (read-first)
   always_comb begin
      rd_ptr_c    = wr_ptr - O_delay[ADDR_WIDTH-1:0];
      rd_word_c   = mem[rd_ptr_c];
      rd_data_c   = rd_word_c[WORD_W-1:1];
      fill_data_c = BLANK_FILL ? '0 : rd_data_c;
   end

   // One entry per cycle regardless of valid; RAM is never cleared
   always_ff @(posedge I_video_clk) begin
      mem[wr_ptr] <= {I_data, I_data_valid};
   end

   always_ff @(posedge I_video_clk) begin
      if (!I_rst_n) begin
         state        <= ST_FILL;
         wr_ptr       <= '0;
         fill_cnt     <= '0;
         O_data       <= '0;
         O_data_valid <= 1'b0;
         O_ready      <= 1'b0;
         O_delay      <= DLY_W'(DEFAULT_DELAY);
         O_delay_err  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (I_delay_load) begin
            // The sample written on the load edge already counts as fresh
            state        <= ST_FILL;
            fill_cnt     <= DLY_W'(1);
            O_delay      <= delay_clamp_c;
            O_delay_err  <= clamp_err_c;
            O_ready      <= 1'b0;
            O_data_valid <= 1'b0;
            O_data       <= fill_data_c;
         end else if (state == ST_FILL) begin
            if (fill_cnt == O_delay) begin
               state        <= ST_RUN;
               O_ready      <= 1'b1;
               O_data_valid <= rd_word_c[0];
               O_data       <= rd_data_c;
            end else begin
               fill_cnt     <= fill_cnt + DLY_W'(1);
               O_ready      <= 1'b0;
               O_data_valid <= 1'b0;
               O_data       <= fill_data_c;
            end
         end else begin
            O_ready      <= 1'b1;
            O_data_valid <= rd_word_c[0];
            O_data       <= rd_data_c;
         end
      end
   end

endmodule

// File: tb/tb_data_delay_prog.sv
// Randomized bench for data_delay_prog against an edge-indexed history model of the delay line.
module tb_data_delay_prog;

`ifdef DATA_DELAY_PROG_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif
   localparam int MAXD = 64;
   localparam int HLEN = 4096;

   logic       clk = 1'b0;
   logic       I_rst_n = 1'b0;
   logic [6:0] I_delay = '0;
   logic       I_delay_load = 1'b0;
   logic       I_data_valid = 1'b0;
   logic [7:0] I_data = '0;
   logic [7:0] O_data;
   logic       O_data_valid;
   logic       O_ready;
   logic [6:0] O_delay;
   logic       O_delay_err;

   data_delay_prog dut (
      .I_video_clk  (clk),
      .I_rst_n      (I_rst_n),
      .I_delay      (I_delay),
      .I_delay_load (I_delay_load),
      .I_data_valid (I_data_valid),
      .I_data       (I_data),
      .O_data       (O_data),
      .O_data_valid (O_data_valid),
      .O_ready      (O_ready),
      .O_delay      (O_delay),
      .O_delay_err  (O_delay_err)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   // Model: every sampled input by edge index, plus the edge from which samples are fresh
   logic [7:0] hist_d [HLEN];
   bit         hist_v [HLEN];
   int         t = 0;
   int         m_start = 0;
   int         m_d = 5;
   bit         m_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", tag, t, got, exp);
      end
   endtask

   task automatic step(input bit rst, input bit ld, input int dly, input bit v, input logic [7:0] d);
      bit rdy;
      int src;
      I_rst_n      = !rst;
      I_delay_load = ld;
      I_delay      = 7'(dly);
      I_data_valid = v;
      I_data       = d;
      @(posedge clk);
      t++;
      hist_d[t] = d;
      hist_v[t] = v;
      if (rst) begin
         m_start = t + 1;
         m_d     = 5;
         m_err   = 1'b0;
      end else if (ld) begin
         m_d     = (dly == 0) ? 1 : (dly > MAXD) ? MAXD : dly;
         m_err   = (dly == 0) || (dly > MAXD);
         m_start = t;
      end
      #1;
      src = t - m_d;
      rdy = !rst && (src >= m_start);
      check("ready", 32'(O_ready), 32'(rdy));
      check("delay", 32'(O_delay), 32'(m_d));
      check("delay_err", 32'(O_delay_err), 32'(m_err));
      check("valid", 32'(O_data_valid), rdy ? 32'(hist_v[src]) : 32'd0);
      if (rdy)
         check("data", 32'(O_data), 32'(hist_d[src]));
      else if (rst || BLANK)
         check("data_blank", 32'(O_data), 32'd0);
   endtask

   initial begin
      bit pat [5];
      pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0;

      step(1, 0, 0, 0, 8'd0);
      step(1, 0, 0, 0, 8'd0);
      // Ramp at default delay
      for (int i = 0; i < 30; i++) step(0, 0, 0, 1, 8'(i));
      // Minimum delay mid-stream
      step(0, 1, 1, 1, 8'd30);
      for (int i = 31; i < 45; i++) step(0, 0, 0, 1, 8'(i));
      // Maximum delay over several pointer wraps
      step(0, 1, 64, 1, 8'($urandom));
      for (int i = 0; i < 200; i++) step(0, 0, 0, 1'($urandom), 8'($urandom));
      // Clamping both ends, then a clean load clears the flag
      step(0, 1, 0, 1, 8'($urandom));
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1'($urandom), 8'($urandom));
      step(0, 1, 100, 1, 8'($urandom));
      for (int i = 0; i < 70; i++) step(0, 0, 0, 1'($urandom), 8'($urandom));
      step(0, 1, 10, 1, 8'($urandom));
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1'($urandom), 8'($urandom));
      // Valid pattern, reload during FILL
      step(0, 1, 3, pat[0], 8'($urandom));
      step(0, 0, 0, pat[1], 8'($urandom));
      step(0, 1, 7, pat[2], 8'($urandom));
      for (int i = 3; i < 40; i++) step(0, 0, 0, pat[i % 5], 8'($urandom));
      // Same-delay reload still refills
      step(0, 1, 7, 1, 8'($urandom));
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1'($urandom), 8'($urandom));
      // One-cycle reset mid-RUN
      step(1, 0, 0, 1, 8'($urandom));
      for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 8'($urandom));
      // Load together with reset: reset wins
      step(0, 1, 30, 1, 8'($urandom));
      for (int i = 0; i < 35; i++) step(0, 0, 0, 1, 8'($urandom));
      step(1, 1, 20, 1, 8'($urandom));
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 8'($urandom));
      // Random loads, delays and occasional resets
      for (int i = 0; i < 600; i++) begin
         bit r;
         bit l;
         r = ($urandom_range(0, 99) == 0);
         l = ($urandom_range(0, 19) == 0);
         step(r, l, int'($urandom_range(0, 127)), 1'($urandom), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
